jt51_eg_rd: RTL and testbench
=============================

JT51_EG_RD -- requirements
Module: jt51_eg_rd

Interface
REQ-001 SHALL have no parameters; the slot count is fixed at 32 and the attenuation width at 10 bits.
REQ-002 SHALL have port clk, input, 1 bit: system clock.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high, sampled on clk.
REQ-004 SHALL have port cen, input, 1 bit: clock enable; capture logic advances only when cen=1.
REQ-005 SHALL have port zero, input, 1 bit: marks the cen cycle in which eg_in carries slot 0.
REQ-006 SHALL have port eg_in, input, 10 bits: time-multiplexed envelope attenuation, one slot per cen cycle, 0x000 loudest, 0x3FF silent.
REQ-007 SHALL have port rd_req, input, 1 bit: read request, held high until rd_ack.
REQ-008 SHALL have port rd_slot, input, 5 bits: slot to read, sampled when a request is accepted.
REQ-009 SHALL have port rd_ack, output, 1 bit: one-clk pulse; rd_data and rd_peak are valid while it is high.
REQ-010 SHALL have port rd_data, output, 10 bits: last captured eg value of the requested slot.
REQ-011 SHALL have port rd_peak, output, 10 bits: minimum eg value of the requested slot since its previous read.
REQ-012 SHALL have port synced, output, 1 bit: set once the first zero has been seen.
REQ-013 SHALL have port all_silent, output, 1 bit: all 32 slots were 0x3FF during the last complete frame.
REQ-014 SHALL have port sync_err, output, 1 bit: sticky; zero arrived while the slot counter was not 31.

Function
REQ-015 SHALL keep a 5-bit slot counter, updated on cen only:
- zero=1 loads 0.
- Otherwise the counter increments, wrapping 31->0.
REQ-016 SHALL ignore eg_in (no captures) while synced=0; the cycle in which zero first arrives is itself captured as slot 0.
REQ-017 SHALL, on each cen cycle with synced=1, write eg_in into the value store at the current slot (32x10).
REQ-018 SHALL, in the same cycle, write min(stored peak, eg_in) into the peak store at the same slot (32x10, unsigned compare).
REQ-019 SHALL, when zero=1 and cen=1 while synced=1 and the counter is not 31, set sync_err and resynchronise to slot 0; sync_err clears only on rst.
REQ-020 SHALL, for silence detection, maintain a frame flag that is the AND over the frame of (eg_in==0x3FF):
- The flag is seeded by the slot-0 sample.
- At each zero, the completed frame's flag is latched into all_silent.
- Frames that end with a resync (REQ-019) SHALL NOT update all_silent.
REQ-021 SHALL run the read handshake as a state machine IDLE -> FETCH -> ACK -> IDLE, independent of cen:
- IDLE: rd_req=1 latches rd_slot and moves to FETCH.
- FETCH: one clk for the store read.
- ACK: rd_ack=1 for one clk, then IDLE.
REQ-022 SHALL assert rd_ack exactly 2 clk after the clk edge at which the request was accepted in IDLE.
REQ-023 SHALL hold rd_data and rd_peak stable from rd_ack until the next rd_ack.
REQ-024 SHALL re-accept a request in the cycle after ACK if rd_req is still high; the requester deasserts rd_req in the cycle it sees rd_ack.
REQ-025 SHALL return in rd_data/rd_peak the store contents as of the FETCH cycle; a capture of the same slot in FETCH is not reflected.
REQ-026 SHALL, in the ACK cycle, reset the peak of the read slot to 0x3FF.
REQ-027 SHALL, if the ACK-cycle peak reset collides with a capture of the same slot, store eg_in as the new peak (the capture wins).
REQ-028 SHALL use unsigned 10-bit arithmetic only; no value exceeds 0x3FF and no overflow handling is needed.

Reset
REQ-029 SHALL, on rst=1, drive the outputs to: rd_ack=0, rd_data=0x3FF, rd_peak=0x3FF, synced=0, all_silent=1, sync_err=0.
REQ-030 SHALL, on rst=1, reset the internal state: slot counter 0, FSM to IDLE, frame flag 1.
REQ-031 SHALL initialise both stores to 0x3FF in every slot, either by a 32-cycle clear sweep after reset or by equivalent reset logic.
REQ-032 SHALL, when a read is in progress during rst, abort it; no rd_ack is issued for the aborted read.
REQ-033 SHALL ignore rd_req during the reset clear sweep, if one is used.

Verification
REQ-034 SHALL be covered by a capture test:
- Stimulus: cen=1 throughout, zero every 32 cycles, eg_in=slot*4.
- Required response: after one frame, a read of slot 9 gives rd_data=0x024 and rd_peak=0x024, with rd_ack 2 clk after acceptance.
REQ-035 SHALL be covered by a peak-hold test:
- Stimulus: slot 3 fed 0x200, then 0x050, then 0x300 in successive frames.
- Required response: read gives rd_data=0x300, rd_peak=0x050; an immediate second read gives rd_peak=0x3FF, or the newer sample if slot 3 was captured in between.
REQ-036 SHALL be covered by a silence test:
- Stimulus: one full frame of 0x3FF, then a frame with slot 17=0x3FE.
- Required response: all_silent=1 after the first zero, then 0 after the next zero.
REQ-037 SHALL be covered by a resync test:
- Stimulus: zero issued at counter=12.
- Required response: sync_err=1 and the slot counter=0; all_silent is unchanged; the next frame captures correctly.
REQ-038 SHALL be covered by a reset-mid-read test:
- Stimulus: rst asserted in FETCH.
- Required response: no rd_ack, outputs at reset values, stores read back 0x3FF.
REQ-039 SHALL be covered by a collision test:
- Stimulus: ACK-cycle peak reset of slot 5 coincides with a capture of slot 5 with eg_in=0x111.
- Required response: the next read of slot 5 gives rd_peak=0x111.

Source files
------------

// File: rtl/jt51_eg_rd.sv
// Envelope attenuation read-back: captures the 32-slot multiplexed eg stream into value/peak
// stores, tracks frame silence and slot sync, and serves single-slot reads over a req/ack handshake.
//
//   state    | meaning
//   ST_IDLE  | waiting for rd_req; latches rd_slot on acceptance
//   ST_FETCH | one clk store read into the output registers
//   ST_ACK   | rd_ack high for one clk; peak of the read slot is reset
module jt51_eg_rd (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       zero,
  input  logic [9:0] eg_in,
  input  logic       rd_req,
  input  logic [4:0] rd_slot,
  output logic       rd_ack,
  output logic [9:0] rd_data,
  output logic [9:0] rd_peak,
  output logic       synced,
  output logic       all_silent,
  output logic       sync_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ACK   = 2'd2
  } rd_state_e;

  localparam logic [9:0] SILENT = 10'h3FF;

  // slot_q holds the slot of the most recent cen sample
  logic [4:0] slot_q, slot_d;
  logic [4:0] cur_slot;
  logic       synced_q, synced_d;
  logic       sync_err_q, sync_err_d;
  logic       frame_q, frame_d;
  logic       all_silent_q, all_silent_d;
  logic       cap_en, frame_end, resync, eg_silent;

  logic [9:0] val_q  [32];
  logic [9:0] peak_q [32];
  logic [9:0] peak_old, cap_peak;
  logic       peak_clr, collide;

  rd_state_e  state_q, state_d;
  logic [4:0] rd_slot_q, rd_slot_d;
  logic [9:0] rd_data_q, rd_data_d;
  logic [9:0] rd_peak_q, rd_peak_d;
  logic       accept, fetch;

  always_comb begin
    cur_slot   = zero ? 5'd0 : slot_q + 5'd1;
    cap_en     = cen & (synced_q | zero);
    frame_end  = cen & zero & synced_q;
    resync     = frame_end & (slot_q != 5'd31);
    eg_silent  = (eg_in == SILENT);
    slot_d     = cen ? cur_slot : slot_q;
    synced_d   = synced_q | (cen & zero);
    sync_err_d = sync_err_q | resync;
    frame_d    = frame_q;
    if (cap_en) frame_d = zero ? eg_silent : (frame_q & eg_silent);
    // a frame cut short by a resync never reaches all_silent
    all_silent_d = all_silent_q;
    if (frame_end && !resync) all_silent_d = frame_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q       <= 5'd0;
      synced_q     <= 1'b0;
      sync_err_q   <= 1'b0;
      frame_q      <= 1'b1;
      all_silent_q <= 1'b1;
    end else begin
      slot_q       <= slot_d;
      synced_q     <= synced_d;
      sync_err_q   <= sync_err_d;
      frame_q      <= frame_d;
      all_silent_q <= all_silent_d;
    end
  end

  // a capture landing on the slot being peak-reset stores the raw sample
  always_comb begin
    peak_old = peak_q[cur_slot];
    peak_clr = (state_q == ST_ACK);
    collide  = peak_clr & cap_en & (cur_slot == rd_slot_q);
    cap_peak = (collide || (eg_in < peak_old)) ? eg_in : peak_old;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        val_q[i]  <= SILENT;
        peak_q[i] <= SILENT;
      end
    end else begin
      if (peak_clr) peak_q[rd_slot_q] <= SILENT;
      if (cap_en) begin
        val_q[cur_slot]  <= eg_in;
        peak_q[cur_slot] <= cap_peak;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (rd_req) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_ACK;
      ST_ACK:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    accept = (state_q == ST_IDLE) & rd_req;
    fetch  = (state_q == ST_FETCH);
    rd_ack = (state_q == ST_ACK);
  end

  // the store read sees contents before any capture on the same edge
  always_comb begin
    rd_slot_d = accept ? rd_slot : rd_slot_q;
    rd_data_d = fetch ? val_q[rd_slot_q]  : rd_data_q;
    rd_peak_d = fetch ? peak_q[rd_slot_q] : rd_peak_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_slot_q <= 5'd0;
      rd_data_q <= SILENT;
      rd_peak_q <= SILENT;
    end else begin
      rd_slot_q <= rd_slot_d;
      rd_data_q <= rd_data_d;
      rd_peak_q <= rd_peak_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_peak    = rd_peak_q;
  assign synced     = synced_q;
  assign all_silent = all_silent_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_jt51_eg_rd.sv
// Directed bench for jt51_eg_rd: a feeder process streams frames from frame_val, tasks
// issue reads and compare against hand-computed values.
module tb_jt51_eg_rd;
  logic       clk = 1'b0;
  logic       rst, cen, zero;
  logic [9:0] eg_in;
  logic       rd_req;
  logic [4:0] rd_slot;
  logic       rd_ack;
  logic [9:0] rd_data, rd_peak;
  logic       synced, all_silent, sync_err;

  int checks = 0;
  int errors = 0;

  logic       feed_en;
  logic [9:0] frame_val [32];
  logic [4:0] fslot;
  int         force_req;
  int         force_seen;

  jt51_eg_rd dut (
    .clk(clk), .rst(rst), .cen(cen), .zero(zero), .eg_in(eg_in),
    .rd_req(rd_req), .rd_slot(rd_slot), .rd_ack(rd_ack), .rd_data(rd_data),
    .rd_peak(rd_peak), .synced(synced), .all_silent(all_silent), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  // feeder: drives the sample for the next edge 1ns after each edge; fslot is the next slot to drive
  initial begin
    cen = 1'b0; zero = 1'b0; eg_in = 10'h000; fslot = 5'd0; force_seen = 0;
    forever begin
      @(posedge clk); #1;
      if (feed_en) begin
        if (force_req != force_seen) begin
          fslot      = 5'd0;
          force_seen = force_req;
        end
        cen   = 1'b1;
        zero  = (fslot == 5'd0);
        eg_in = frame_val[fslot];
        fslot = fslot + 5'd1;
      end else begin
        cen  = 1'b0;
        zero = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic wait_fslot(input logic [4:0] v);
    for (int n = 0; n < 70 && fslot != v; n++) tick();
    if (fslot != v) begin
      checks++; errors++;
      $display("FAIL wait_fslot: feeder slot %0d, required %0d", fslot, v);
    end
  endtask

  // issue one read; lat counts clk edges from the accepting edge (inclusive) to rd_ack; ends in IDLE
  task automatic read_slot(input logic [4:0] s, output logic [9:0] d, output logic [9:0] p, output int lat);
    bit got = 0;
    d = 10'h000; p = 10'h000; lat = 0;
    rd_slot = s; rd_req = 1'b1;
    for (int n = 0; n < 8 && !got; n++) begin
      tick(); lat++;
      if (rd_ack === 1'b1) begin got = 1; d = rd_data; p = rd_peak; end
    end
    rd_req = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL read_timeout slot %0d: no rd_ack within 8 clk, required at 2", s);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks += 6;
    if (rd_ack !== 1'b0)      begin errors++; $display("FAIL rst_ack got %b exp 0", rd_ack); end
    if (rd_data !== 10'h3FF)  begin errors++; $display("FAIL rst_data got %h exp 3ff", rd_data); end
    if (rd_peak !== 10'h3FF)  begin errors++; $display("FAIL rst_peak got %h exp 3ff", rd_peak); end
    if (synced !== 1'b0)      begin errors++; $display("FAIL rst_synced got %b exp 0", synced); end
    if (all_silent !== 1'b1)  begin errors++; $display("FAIL rst_silent got %b exp 1", all_silent); end
    if (sync_err !== 1'b0)    begin errors++; $display("FAIL rst_syncerr got %b exp 0", sync_err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_capture();
    logic [9:0] d, p; int lat;
    for (int i = 0; i < 32; i++) frame_val[i] = 10'(i * 4);
    feed_en = 1'b1;
    repeat (40) tick();
    feed_en = 1'b0;
    tick(); tick();
    checks += 3;
    if (synced !== 1'b1)     begin errors++; $display("FAIL cap_synced got %b exp 1", synced); end
    if (all_silent !== 1'b0) begin errors++; $display("FAIL cap_silent got %b exp 0", all_silent); end
    if (sync_err !== 1'b0)   begin errors++; $display("FAIL cap_syncerr got %b exp 0", sync_err); end
    read_slot(5'd9, d, p, lat);
    checks += 3;
    if (d !== 10'h024) begin errors++; $display("FAIL cap_data9 got %h exp 024", d); end
    if (p !== 10'h024) begin errors++; $display("FAIL cap_peak9 got %h exp 024", p); end
    if (lat !== 2)     begin errors++; $display("FAIL cap_latency got %0d exp 2", lat); end
    read_slot(5'd31, d, p, lat);
    checks++;
    if (d !== 10'h07C) begin errors++; $display("FAIL cap_data31 got %h exp 07c", d); end
  endtask

  task automatic test_peak_hold();
    logic [9:0] d, p; int lat;
    read_slot(5'd3, d, p, lat);
    checks += 2;
    if (d !== 10'h00C) begin errors++; $display("FAIL peak_pre_data got %h exp 00c", d); end
    if (p !== 10'h00C) begin errors++; $display("FAIL peak_pre_peak got %h exp 00c", p); end
    frame_val[3] = 10'h200;
    feed_en = 1'b1;
    tick(); wait_fslot(5'd4);
    frame_val[3] = 10'h050;
    tick(); wait_fslot(5'd4);
    frame_val[3] = 10'h300;
    tick(); wait_fslot(5'd4);
    feed_en = 1'b0;
    tick(); tick();
    read_slot(5'd3, d, p, lat);
    checks += 2;
    if (d !== 10'h300) begin errors++; $display("FAIL peak_data got %h exp 300", d); end
    if (p !== 10'h050) begin errors++; $display("FAIL peak_min got %h exp 050", p); end
    read_slot(5'd3, d, p, lat);
    checks += 2;
    if (d !== 10'h300) begin errors++; $display("FAIL peak_again_data got %h exp 300", d); end
    if (p !== 10'h3FF) begin errors++; $display("FAIL peak_cleared got %h exp 3ff", p); end
  endtask

  task automatic test_silence();
    for (int i = 0; i < 32; i++) frame_val[i] = 10'h3FF;
    feed_en = 1'b1;
    tick(); wait_fslot(5'd1);
    checks++;
    if (all_silent !== 1'b0) begin errors++; $display("FAIL sil_before got %b exp 0", all_silent); end
    tick();
    tick(); wait_fslot(5'd1);
    tick();
    checks++;
    if (all_silent !== 1'b1) begin errors++; $display("FAIL sil_quiet_frame got %b exp 1", all_silent); end
    frame_val[17] = 10'h3FE;
    tick(); wait_fslot(5'd1);
    checks++;
    if (all_silent !== 1'b1) begin errors++; $display("FAIL sil_hold got %b exp 1", all_silent); end
    tick();
    checks++;
    if (all_silent !== 1'b0) begin errors++; $display("FAIL sil_loud_frame got %b exp 0", all_silent); end
    frame_val[17] = 10'h3FF;
  endtask

  task automatic test_resync();
    logic [9:0] d, p; int lat;
    checks++;
    if (sync_err !== 1'b0) begin errors++; $display("FAIL resync_pre got %b exp 0", sync_err); end
    wait_fslot(5'd13);
    for (int i = 0; i < 32; i++) frame_val[i] = 10'h100 + 10'(i);
    force_req++;
    tick(); tick();
    checks += 2;
    if (sync_err !== 1'b1)   begin errors++; $display("FAIL resync_err got %b exp 1", sync_err); end
    if (all_silent !== 1'b0) begin errors++; $display("FAIL resync_silent got %b exp 0", all_silent); end
    wait_fslot(5'd20);
    feed_en = 1'b0;
    tick(); tick();
    read_slot(5'd12, d, p, lat);
    checks++;
    if (d !== 10'h10C) begin errors++; $display("FAIL resync_data12 got %h exp 10c", d); end
    read_slot(5'd13, d, p, lat);
    checks++;
    if (d !== 10'h10D) begin errors++; $display("FAIL resync_data13 got %h exp 10d", d); end
    read_slot(5'd0, d, p, lat);
    checks += 2;
    if (d !== 10'h100)     begin errors++; $display("FAIL resync_data0 got %h exp 100", d); end
    if (sync_err !== 1'b1) begin errors++; $display("FAIL resync_sticky got %b exp 1", sync_err); end
  endtask

  task automatic test_collision();
    logic [9:0] d, p; int lat;
    frame_val[5] = 10'h111;
    feed_en = 1'b1;
    tick(); wait_fslot(5'd4);
    // ACK cycle of this read coincides with the capture of slot 5
    read_slot(5'd5, d, p, lat);
    checks += 2;
    if (d !== 10'h105) begin errors++; $display("FAIL coll_first_data got %h exp 105", d); end
    if (p !== 10'h014) begin errors++; $display("FAIL coll_first_peak got %h exp 014", p); end
    frame_val[5] = 10'h1FF;
    wait_fslot(5'd6);
    // slot 6 is captured on the FETCH edge of this read
    frame_val[6] = 10'h066;
    read_slot(5'd6, d, p, lat);
    feed_en = 1'b0;
    checks += 2;
    if (d !== 10'h106) begin errors++; $display("FAIL fetch_snap_data got %h exp 106", d); end
    if (p !== 10'h018) begin errors++; $display("FAIL fetch_snap_peak got %h exp 018", p); end
    tick(); tick();
    read_slot(5'd5, d, p, lat);
    checks += 2;
    if (d !== 10'h1FF) begin errors++; $display("FAIL coll_data got %h exp 1ff", d); end
    if (p !== 10'h111) begin errors++; $display("FAIL coll_peak got %h exp 111", p); end
    read_slot(5'd6, d, p, lat);
    checks += 2;
    if (d !== 10'h066) begin errors++; $display("FAIL fetch_after_data got %h exp 066", d); end
    if (p !== 10'h3FF) begin errors++; $display("FAIL fetch_after_peak got %h exp 3ff", p); end
  endtask

  task automatic test_back_to_back();
    logic ack_seq [5];
    logic exp_seq [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [9:0] d1, p1, p_mid;
    rd_slot = 5'd9; rd_req = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      ack_seq[n] = rd_ack;
      if (n == 1) begin d1 = rd_data; p1 = rd_peak; end
      if (n == 3) p_mid = rd_peak;
    end
    rd_req = 1'b0;
    for (int n = 0; n < 5; n++) begin
      checks++;
      if (ack_seq[n] !== exp_seq[n]) begin errors++; $display("FAIL b2b_ack clk %0d got %b exp %b", n + 1, ack_seq[n], exp_seq[n]); end
    end
    checks += 5;
    if (d1 !== 10'h109)      begin errors++; $display("FAIL b2b_data1 got %h exp 109", d1); end
    if (p1 !== 10'h024)      begin errors++; $display("FAIL b2b_peak1 got %h exp 024", p1); end
    if (p_mid !== 10'h024)   begin errors++; $display("FAIL b2b_peak_hold got %h exp 024", p_mid); end
    if (rd_data !== 10'h109) begin errors++; $display("FAIL b2b_data2 got %h exp 109", rd_data); end
    if (rd_peak !== 10'h3FF) begin errors++; $display("FAIL b2b_peak2 got %h exp 3ff", rd_peak); end
    tick();
  endtask

  task automatic test_reset_mid_read();
    logic [9:0] d, p; int lat;
    rd_slot = 5'd9; rd_req = 1'b1;
    tick();
    rd_req = 1'b0; rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++;
      if (rd_ack !== 1'b0) begin errors++; $display("FAIL rmr_ack_in_rst clk %0d got %b exp 0", n, rd_ack); end
    end
    rst = 1'b0;
    tick();
    checks += 6;
    if (rd_ack !== 1'b0)     begin errors++; $display("FAIL rmr_ack got %b exp 0", rd_ack); end
    if (rd_data !== 10'h3FF) begin errors++; $display("FAIL rmr_data got %h exp 3ff", rd_data); end
    if (rd_peak !== 10'h3FF) begin errors++; $display("FAIL rmr_peak got %h exp 3ff", rd_peak); end
    if (synced !== 1'b0)     begin errors++; $display("FAIL rmr_synced got %b exp 0", synced); end
    if (all_silent !== 1'b1) begin errors++; $display("FAIL rmr_silent got %b exp 1", all_silent); end
    if (sync_err !== 1'b0)   begin errors++; $display("FAIL rmr_syncerr got %b exp 0", sync_err); end
    read_slot(5'd9, d, p, lat);
    checks += 2;
    if (d !== 10'h3FF) begin errors++; $display("FAIL rmr_store9_data got %h exp 3ff", d); end
    if (p !== 10'h3FF) begin errors++; $display("FAIL rmr_store9_peak got %h exp 3ff", p); end
    read_slot(5'd5, d, p, lat);
    checks += 2;
    if (d !== 10'h3FF) begin errors++; $display("FAIL rmr_store5_data got %h exp 3ff", d); end
    if (p !== 10'h3FF) begin errors++; $display("FAIL rmr_store5_peak got %h exp 3ff", p); end
  endtask

  initial begin
    rst = 1'b1; rd_req = 1'b0; rd_slot = 5'd0;
    feed_en = 1'b0; force_req = 0;
    for (int i = 0; i < 32; i++) frame_val[i] = 10'h3FF;
    test_reset();
    test_capture();
    test_peak_hold();
    test_silence();
    test_resync();
    test_collision();
    test_back_to_back();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
